btb_write_scheduler: RTL and testbench
======================================

# btb_write_scheduler

Owns the single write port of the branch target buffer RAM. Arbitrates among three write sources: a full-table flush sequencer, a debug/config write port, and a small FIFO of branch-resolution updates. Sits between the branch-resolution/commit logic and the BTB RAM; drives the RAM's `addr0wr_i`/`data0wr_i`/`we0_i`. Optionally forwards still-pending updates onto the fetch-side read data.

## Interface
- `DEPTH`, default 64: BTB entries.
- `INDEX`, default 6: BTB index width, equal to log2(DEPTH).
- `WIDTH`, default 32: BTB entry width.
- `QDEPTH`, default 4: update FIFO entries, power of two, ≥2.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `upd_valid_i` in 1: resolution update valid.
- `upd_addr_i` in INDEX: update index.
- `upd_data_i` in WIDTH: update entry.
- `upd_ready_o` out 1: FIFO can accept an update.
- `cfg_we_i` in 1: debug/config write strobe; always accepted.
- `cfg_addr_i` in INDEX: config index.
- `cfg_data_i` in WIDTH: config entry.
- `flush_i` in 1: single-cycle request to clear the whole table.
- `flush_busy_o` out 1: flush sequence in progress.
- `ram_addr_o` out INDEX: to the RAM write address.
- `ram_data_o` out WIDTH: to the RAM write data.
- `ram_we_o` out 1: to the RAM write enable.
- `rd_addr_i` in INDEX: fetch read index, same value as the RAM read address.
- `ram_rd_data_i` in WIDTH: RAM read data.
- `rd_data_o` out WIDTH: read data delivered to fetch.
- `q_count_o` out $clog2(QDEPTH+1): FIFO occupancy.

## Operation
- Two-state FSM: IDLE and FLUSH.
- IDLE → FLUSH when `flush_i`=1. Entering FLUSH clears the FIFO (count=0), including any update accepted in that same cycle, and loads the flush counter with 0.
- In FLUSH, one write per cycle: `ram_we_o`=1, `ram_addr_o`=counter, `ram_data_o`=0, then the counter increments.
- FLUSH → IDLE on the cycle after address DEPTH-1 is written, so FLUSH lasts exactly DEPTH cycles.
- In FLUSH, `flush_i` is ignored (no restart) and `cfg_we_i` is dropped.
- Write priority in IDLE: config first, then the FIFO head.
  - `cfg_we_i`=1: write the cfg address/data; the FIFO does not pop.
  - Otherwise, if the FIFO is non-empty: write the head and pop it in the same cycle.
  - Otherwise `ram_we_o`=0.
- The write outputs are combinational from state, cfg inputs and FIFO head. The RAM commits the write at the next edge.
- `upd_ready_o` = (state==IDLE) && (count<QDEPTH), computed from registered state only.
  - When the FIFO is full, a push and a pop in the same cycle are not both allowed, because ready is already 0.
  - When count<QDEPTH, simultaneous push and pop leave count unchanged.
- Pointers wrap modulo QDEPTH. The count saturates by construction, never above QDEPTH.
- Updates leave the FIFO in order. Two pending updates to the same index both write; the younger one wins.
- Reset values:
  - state IDLE, FIFO empty, `q_count_o`=0, `upd_ready_o`=1.
  - `flush_busy_o`=0, `ram_we_o`=0.
  - `ram_addr_o`=0, `ram_data_o`=0.
- Reset asserted mid-flush returns the block to IDLE immediately. The RAM's own reset clears its contents.

## Timing
- Update accepted at edge N reaches the RAM write port at N+1 at the earliest, and is visible on RAM read data from N+2.
- Config write: zero-cycle pass-through onto the write port.
- `flush_busy_o` goes high the cycle after `flush_i` and stays high for DEPTH cycles.
- `upd_ready_o` goes low in the same cycles as `flush_busy_o`.
- `rd_data_o` is combinational from `rd_addr_i`, `ram_rd_data_i` and FIFO contents.

## Configuration
- `BTB_UPD_BYPASS_EN` defined:
  - `rd_data_o` = data of the youngest valid FIFO entry whose index equals `rd_addr_i`, else `ram_rd_data_i`.
  - The entry being written this cycle still counts as pending.
  - During FLUSH, `rd_data_o`=0.
- `BTB_UPD_BYPASS_EN` undefined: `rd_data_o` = `ram_rd_data_i` always, and there is no compare logic.

## Structure
- Package `btb_ctrl_pkg`: the IDLE/FLUSH state enum, and a `btb_upd_t` struct holding index and data.
- Sub-module `btb_upd_fifo`: parameterised circular FIFO.
  - Controls: push, pop, clear.
  - Exposes head, count, and per-entry valid/addr/data vectors for the bypass logic.
- The top level contains the FSM, the flush counter, the arbiter and the bypass mux.

## Test plan
- After reset, push updates (3,0xA), (5,0xB) on consecutive cycles → writes of idx 3 then 5 on the next two cycles; `q_count_o` peaks at 1.
- Hold `cfg_we_i` for 6 cycles while pushing 5 updates → ready falls after 4 accepts. No update writes during the cfg cycles. The FIFO then drains in order over 4 cycles.
- `flush_i` with 2 pending updates → FIFO cleared, 64 zero writes to idx 0..63 in order, busy for 64 cycles, ready low throughout, and no pending update is ever written.
- `flush_i` asserted again mid-flush, then `reset` at flush cycle 20 → no restart on the second `flush_i`; after reset the block is in IDLE with all outputs at their reset values.
- With `BTB_UPD_BYPASS_EN`: push (7,0x11) then (7,0x22) under cfg stall, read idx 7 → `rd_data_o`=0x22. Without the macro: `rd_data_o` equals `ram_rd_data_i`.
- Same-cycle `upd_valid_i` and `flush_i` in IDLE → the update is dropped and never written.

Source files
------------

// File: rtl/btb_ctrl_pkg.sv
// Shared types for the BTB write scheduler: FSM state encoding and the
// resolution-update record (index + entry) using the default BTB geometry.
package btb_ctrl_pkg;

   localparam int BTB_INDEX_W = 6;
   localparam int BTB_WIDTH_W = 32;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FLUSH = 1'b1
   } btb_state_e;

   typedef struct packed {
      logic [BTB_INDEX_W-1:0] idx;
      logic [BTB_WIDTH_W-1:0] data;
   } btb_upd_t;

endpackage

// File: rtl/btb_upd_fifo.sv
// Circular FIFO of pending branch-resolution updates. Besides the head it
// exposes every slot in age order (slot 0 = oldest) so a reader can bypass.
module btb_upd_fifo
   import btb_ctrl_pkg::*;
#(
   parameter  int INDEX  = 6,
   parameter  int WIDTH  = 32,
   parameter  int QDEPTH = 4,
   localparam int PW     = $clog2(QDEPTH),
   localparam int CW     = $clog2(QDEPTH+1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push_i,
   input  logic [INDEX-1:0]        push_addr_i,
   input  logic [WIDTH-1:0]        push_data_i,
   input  logic                    pop_i,
   input  logic                    clear_i,
   output logic [INDEX-1:0]        head_addr_o,
   output logic [WIDTH-1:0]        head_data_o,
   output logic [CW-1:0]           count_o,
   output logic [QDEPTH-1:0]       ent_valid_o,
   output logic [QDEPTH*INDEX-1:0] ent_addr_o,
   output logic [QDEPTH*WIDTH-1:0] ent_data_o
);

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [INDEX-1:0] mem_addr_q [QDEPTH];
   logic [INDEX-1:0] mem_addr_d [QDEPTH];
   logic [WIDTH-1:0] mem_data_q [QDEPTH];
   logic [WIDTH-1:0] mem_data_d [QDEPTH];

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      if (clear_i) begin
         // Clear wins over a same-cycle push: that update is discarded.
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) begin
            mem_addr_d[wr_ptr_q] = push_addr_i;
            mem_data_d[wr_ptr_q] = push_data_i;
            wr_ptr_d             = wr_ptr_q + PW'(1);
         end
         if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; occupancy alone decides what is meaningful.
   always_ff @(posedge clk) begin
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
   end

   assign head_addr_o = mem_addr_q[rd_ptr_q];
   assign head_data_o = mem_data_q[rd_ptr_q];
   assign count_o     = count_q;

   always_comb begin
      ent_valid_o = '0;
      ent_addr_o  = '0;
      ent_data_o  = '0;
      for (int k = 0; k < QDEPTH; k++) begin
         ent_valid_o[k]                = (CW'(k) < count_q);
         ent_addr_o[k*INDEX +: INDEX]  = mem_addr_q[rd_ptr_q + PW'(k)];
         ent_data_o[k*WIDTH +: WIDTH]  = mem_data_q[rd_ptr_q + PW'(k)];
      end
   end

endmodule

// File: rtl/btb_write_scheduler.sv
// Owns the BTB RAM write port: flush sequencer > config write > update FIFO.
// Define BTB_UPD_BYPASS_EN to forward pending FIFO updates onto fetch read data.
module btb_write_scheduler
   import btb_ctrl_pkg::*;
#(
   parameter  int DEPTH  = 64,
   parameter  int INDEX  = 6,
   parameter  int WIDTH  = 32,
   parameter  int QDEPTH = 4,
   localparam int CW     = $clog2(QDEPTH+1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             upd_valid_i,
   input  logic [INDEX-1:0] upd_addr_i,
   input  logic [WIDTH-1:0] upd_data_i,
   output logic             upd_ready_o,
   input  logic             cfg_we_i,
   input  logic [INDEX-1:0] cfg_addr_i,
   input  logic [WIDTH-1:0] cfg_data_i,
   input  logic             flush_i,
   output logic             flush_busy_o,
   output logic [INDEX-1:0] ram_addr_o,
   output logic [WIDTH-1:0] ram_data_o,
   output logic             ram_we_o,
   input  logic [INDEX-1:0] rd_addr_i,
   input  logic [WIDTH-1:0] ram_rd_data_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic [CW-1:0]    q_count_o
);

   btb_state_e state_q, state_d;
   logic [INDEX-1:0] cnt_q, cnt_d;

   logic                    fifo_push, fifo_pop, fifo_clear;
   logic [INDEX-1:0]        head_addr;
   logic [WIDTH-1:0]        head_data;
   logic [QDEPTH-1:0]       ent_valid;
   logic [QDEPTH*INDEX-1:0] ent_addr;
   logic [QDEPTH*WIDTH-1:0] ent_data;

   assign upd_ready_o  = (state_q == ST_IDLE) && (q_count_o < CW'(QDEPTH));
   assign flush_busy_o = (state_q == ST_FLUSH);
   assign fifo_push    = upd_valid_i && upd_ready_o;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ram_we_o   = 1'b0;
      ram_addr_o = '0;
      ram_data_o = '0;
      fifo_pop   = 1'b0;
      fifo_clear = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cfg_we_i) begin
               ram_we_o   = 1'b1;
               ram_addr_o = cfg_addr_i;
               ram_data_o = cfg_data_i;
            end else if (!flush_i && (q_count_o != '0)) begin
               // A head about to be discarded by the flush is not written.
               ram_we_o   = 1'b1;
               ram_addr_o = head_addr;
               ram_data_o = head_data;
               fifo_pop   = 1'b1;
            end
            if (flush_i) begin
               state_d    = ST_FLUSH;
               cnt_d      = '0;
               fifo_clear = 1'b1;
            end
         end
         ST_FLUSH: begin
            ram_we_o   = 1'b1;
            ram_addr_o = cnt_q;
            cnt_d      = cnt_q + INDEX'(1);
            if (cnt_q == INDEX'(DEPTH-1)) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   btb_upd_fifo #(
      .INDEX  (INDEX),
      .WIDTH  (WIDTH),
      .QDEPTH (QDEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (fifo_push),
      .push_addr_i (upd_addr_i),
      .push_data_i (upd_data_i),
      .pop_i       (fifo_pop),
      .clear_i     (fifo_clear),
      .head_addr_o (head_addr),
      .head_data_o (head_data),
      .count_o     (q_count_o),
      .ent_valid_o (ent_valid),
      .ent_addr_o  (ent_addr),
      .ent_data_o  (ent_data)
   );

`ifdef BTB_UPD_BYPASS_EN
   // Later slots are younger, so the last match in the scan wins.
   always_comb begin
      rd_data_o = ram_rd_data_i;
      for (int k = 0; k < QDEPTH; k++) begin
         if (ent_valid[k] && (ent_addr[k*INDEX +: INDEX] == rd_addr_i)) begin
            rd_data_o = ent_data[k*WIDTH +: WIDTH];
         end
      end
      if (state_q == ST_FLUSH) begin
         rd_data_o = '0;
      end
   end
`else
   assign rd_data_o = ram_rd_data_i;
   logic unused_bypass;
   assign unused_bypass = ^{ent_valid, ent_addr, ent_data, rd_addr_i};
`endif

endmodule

// File: tb/tb_btb_write_scheduler.sv
// Directed bench for btb_write_scheduler: arbitration, FIFO order/backpressure,
// flush sequencing, reset mid-flush and optional read bypass.
module tb_btb_write_scheduler;
   import btb_ctrl_pkg::*;

   localparam int DEPTH  = 64;
   localparam int INDEX  = 6;
   localparam int WIDTH  = 32;
   localparam int QDEPTH = 4;
   localparam int CW     = $clog2(QDEPTH+1);

   logic             clk;
   logic             reset;
   logic             upd_valid_i;
   logic [INDEX-1:0] upd_addr_i;
   logic [WIDTH-1:0] upd_data_i;
   logic             upd_ready_o;
   logic             cfg_we_i;
   logic [INDEX-1:0] cfg_addr_i;
   logic [WIDTH-1:0] cfg_data_i;
   logic             flush_i;
   logic             flush_busy_o;
   logic [INDEX-1:0] ram_addr_o;
   logic [WIDTH-1:0] ram_data_o;
   logic             ram_we_o;
   logic [INDEX-1:0] rd_addr_i;
   logic [WIDTH-1:0] ram_rd_data_i;
   logic [WIDTH-1:0] rd_data_o;
   logic [CW-1:0]    q_count_o;

   int checks = 0;
   int errors = 0;
   btb_upd_t tbl [5];

   btb_write_scheduler #(
      .DEPTH  (DEPTH),
      .INDEX  (INDEX),
      .WIDTH  (WIDTH),
      .QDEPTH (QDEPTH)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .upd_valid_i   (upd_valid_i),
      .upd_addr_i    (upd_addr_i),
      .upd_data_i    (upd_data_i),
      .upd_ready_o   (upd_ready_o),
      .cfg_we_i      (cfg_we_i),
      .cfg_addr_i    (cfg_addr_i),
      .cfg_data_i    (cfg_data_i),
      .flush_i       (flush_i),
      .flush_busy_o  (flush_busy_o),
      .ram_addr_o    (ram_addr_o),
      .ram_data_o    (ram_data_o),
      .ram_we_o      (ram_we_o),
      .rd_addr_i     (rd_addr_i),
      .ram_rd_data_i (ram_rd_data_i),
      .rd_data_o     (rd_data_o),
      .q_count_o     (q_count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_busy"},  64'(flush_busy_o), 64'd0);
      chk({tag, "_ready"}, 64'(upd_ready_o),  64'd1);
      chk({tag, "_we"},    64'(ram_we_o),     64'd0);
      chk({tag, "_addr"},  64'(ram_addr_o),   64'd0);
      chk({tag, "_data"},  64'(ram_data_o),   64'd0);
      chk({tag, "_cnt"},   64'(q_count_o),    64'd0);
   endtask

   // Runs n flush cycles from the first FLUSH cycle; pokes flush_i, cfg and
   // upd_valid mid-way, none of which may disturb the zero-write sweep.
   task automatic flush_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         flush_i     = (i == 5);
         cfg_we_i    = (i >= 10 && i < 13);
         cfg_addr_i  = 6'd9;
         cfg_data_i  = 32'hFFFF_FFFF;
         upd_valid_i = (i == 30);
         ram_rd_data_i = 32'h5A5A_0000 + 32'(i);
         #1;
         chk("fl_busy",  64'(flush_busy_o), 64'd1);
         chk("fl_ready", 64'(upd_ready_o),  64'd0);
         chk("fl_we",    64'(ram_we_o),     64'd1);
         chk("fl_addr",  64'(ram_addr_o),   64'(i));
         chk("fl_data",  64'(ram_data_o),   64'd0);
         chk("fl_cnt",   64'(q_count_o),    64'd0);
`ifdef BTB_UPD_BYPASS_EN
         chk("fl_rd",    64'(rd_data_o),    64'd0);
`else
         chk("fl_rd",    64'(rd_data_o),    64'h5A5A_0000 + 64'(i));
`endif
      end
   endtask

   initial begin
      tbl[0] = '{idx: 6'd1, data: 32'h101};
      tbl[1] = '{idx: 6'd2, data: 32'h102};
      tbl[2] = '{idx: 6'd3, data: 32'h103};
      tbl[3] = '{idx: 6'd4, data: 32'h104};
      tbl[4] = '{idx: 6'd5, data: 32'h105};

      reset = 1'b1; upd_valid_i = 1'b0; upd_addr_i = '0; upd_data_i = '0;
      cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_data_i = '0; flush_i = 1'b0;
      rd_addr_i = '0; ram_rd_data_i = '0;

      tick(); tick(); #1;
      chk_idle_outputs("rst");
      tick();
      reset = 1'b0;

      // Two back-to-back updates: each written the cycle after acceptance.
      upd_valid_i = 1'b1; upd_addr_i = 6'd3; upd_data_i = 32'hA; #1;
      chk("t1_we0",  64'(ram_we_o),  64'd0);
      chk("t1_cnt0", 64'(q_count_o), 64'd0);
      tick();
      upd_addr_i = 6'd5; upd_data_i = 32'hB; #1;
      chk("t1_cnt1", 64'(q_count_o),  64'd1);
      chk("t1_we1",  64'(ram_we_o),   64'd1);
      chk("t1_a1",   64'(ram_addr_o), 64'd3);
      chk("t1_d1",   64'(ram_data_o), 64'hA);
      tick();
      upd_valid_i = 1'b0; #1;
      chk("t1_cnt2", 64'(q_count_o),  64'd1);
      chk("t1_we2",  64'(ram_we_o),   64'd1);
      chk("t1_a2",   64'(ram_addr_o), 64'd5);
      chk("t1_d2",   64'(ram_data_o), 64'hB);
      tick(); #1;
      chk("t1_cnt3", 64'(q_count_o), 64'd0);
      chk("t1_we3",  64'(ram_we_o),  64'd0);

      // Config holds the port for 6 cycles; FIFO fills to 4 and back-pressures.
      for (int k = 0; k < 6; k++) begin
         tick();
         cfg_we_i    = 1'b1;
         cfg_addr_i  = 6'(10 + k);
         cfg_data_i  = 32'hC0 + 32'(k);
         upd_valid_i = (k < 5);
         upd_addr_i  = tbl[k < 5 ? k : 4].idx;
         upd_data_i  = tbl[k < 5 ? k : 4].data;
         #1;
         chk("t2_we",    64'(ram_we_o),    64'd1);
         chk("t2_addr",  64'(ram_addr_o),  64'(10 + k));
         chk("t2_data",  64'(ram_data_o),  64'h0C0 + 64'(k));
         chk("t2_cnt",   64'(q_count_o),   64'(k < 4 ? k : 4));
         chk("t2_ready", 64'(upd_ready_o), 64'(k < 4));
      end
      for (int j = 0; j < 4; j++) begin
         tick();
         cfg_we_i = 1'b0; upd_valid_i = 1'b0; #1;
         chk("t2_dr_we",    64'(ram_we_o),    64'd1);
         chk("t2_dr_addr",  64'(ram_addr_o),  64'(tbl[j].idx));
         chk("t2_dr_data",  64'(ram_data_o),  64'(tbl[j].data));
         chk("t2_dr_cnt",   64'(q_count_o),   64'(4 - j));
         chk("t2_dr_ready", 64'(upd_ready_o), 64'(j != 0));
      end
      tick(); #1;
      chk("t2_end_we",  64'(ram_we_o),  64'd0);
      chk("t2_end_cnt", 64'(q_count_o), 64'd0);

      // Two pending updates to index 7 under config stall; read index 7.
      tick();
      cfg_we_i = 1'b1; cfg_addr_i = 6'd2; cfg_data_i = 32'h5;
      upd_valid_i = 1'b1; upd_addr_i = 6'd7; upd_data_i = 32'h11; #1;
      tick();
      upd_data_i = 32'h22; #1;
      tick();
      upd_valid_i = 1'b0; rd_addr_i = 6'd7; ram_rd_data_i = 32'hDEAD_0007; #1;
      chk("t5_cnt", 64'(q_count_o), 64'd2);
`ifdef BTB_UPD_BYPASS_EN
      chk("t5_rd7", 64'(rd_data_o), 64'h22);
`else
      chk("t5_rd7", 64'(rd_data_o), 64'hDEAD_0007);
`endif
      rd_addr_i = 6'd8; ram_rd_data_i = 32'hDEAD_0008; #1;
      chk("t5_rd8", 64'(rd_data_o), 64'hDEAD_0008);
      tick();
      cfg_we_i = 1'b0; rd_addr_i = 6'd7; ram_rd_data_i = 32'hDEAD_0007; #1;
      chk("t5_we1", 64'(ram_we_o),   64'd1);
      chk("t5_a1",  64'(ram_addr_o), 64'd7);
      chk("t5_d1",  64'(ram_data_o), 64'h11);
`ifdef BTB_UPD_BYPASS_EN
      chk("t5_rd_p1", 64'(rd_data_o), 64'h22);
`else
      chk("t5_rd_p1", 64'(rd_data_o), 64'hDEAD_0007);
`endif
      tick(); #1;
      chk("t5_we2", 64'(ram_we_o),   64'd1);
      chk("t5_a2",  64'(ram_addr_o), 64'd7);
      chk("t5_d2",  64'(ram_data_o), 64'h22);
`ifdef BTB_UPD_BYPASS_EN
      chk("t5_rd_p2", 64'(rd_data_o), 64'h22);
`else
      chk("t5_rd_p2", 64'(rd_data_o), 64'hDEAD_0007);
`endif
      tick(); #1;
      chk("t5_we3",   64'(ram_we_o),  64'd0);
      chk("t5_rd_p3", 64'(rd_data_o), 64'hDEAD_0007);

      // Flush with two updates pending: they are discarded, never written.
      tick();
      cfg_we_i = 1'b1; cfg_addr_i = 6'd1; cfg_data_i = 32'h1;
      upd_valid_i = 1'b1; upd_addr_i = 6'd20; upd_data_i = 32'h201; #1;
      tick();
      upd_addr_i = 6'd21; upd_data_i = 32'h202; #1;
      tick();
      cfg_we_i = 1'b0; upd_valid_i = 1'b0; flush_i = 1'b1; #1;
      chk("t3_f0_we",    64'(ram_we_o),     64'd0);
      chk("t3_f0_cnt",   64'(q_count_o),    64'd2);
      chk("t3_f0_busy",  64'(flush_busy_o), 64'd0);
      chk("t3_f0_ready", 64'(upd_ready_o),  64'd1);
      flush_cycles(DEPTH);
      tick();
      flush_i = 1'b0; cfg_we_i = 1'b0; upd_valid_i = 1'b0; #1;
      chk_idle_outputs("t3_end");
      tick(); #1;
      chk("t3_end_we2", 64'(ram_we_o), 64'd0);

      // Update in the same cycle as flush_i is dropped.
      tick();
      upd_valid_i = 1'b1; upd_addr_i = 6'd33; upd_data_i = 32'h333; flush_i = 1'b1; #1;
      chk("t6_we",    64'(ram_we_o),    64'd0);
      chk("t6_ready", 64'(upd_ready_o), 64'd1);
      flush_cycles(DEPTH);
      tick();
      flush_i = 1'b0; cfg_we_i = 1'b0; upd_valid_i = 1'b0; #1;
      chk_idle_outputs("t6_end");
      tick(); #1;
      chk("t6_end_we2", 64'(ram_we_o), 64'd0);

      // Flush, second flush_i mid-way, reset at flush cycle 20.
      tick();
      flush_i = 1'b1; #1;
      flush_cycles(20);
      tick();
      flush_i = 1'b0; cfg_we_i = 1'b0; upd_valid_i = 1'b0; reset = 1'b1; #1;
      chk("t4_pre_busy", 64'(flush_busy_o), 64'd1);
      chk("t4_pre_addr", 64'(ram_addr_o),   64'd20);
      tick(); #1;
      chk_idle_outputs("t4_rst");
      tick();
      reset = 1'b0; #1;
      chk_idle_outputs("t4_post");
      tick(); #1;
      chk("t4_post_busy2", 64'(flush_busy_o), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
